ft_sync_fifo_bridge: RTL

Synchronous FT-style 245 FIFO bridge with two independent queues, parametrised in data width and depth.
- Down queue: host to local. The host writes with wr; local logic pops through a valid/ready stream.
- Up queue: local to host. Local logic pushes through a valid/ready stream; the host reads with oe/rd.
- Adds behaviour the single-queue model lacks: a bus-turnaround FSM, full-depth occupancy, and overflow/underflow/protocol error reporting.
- Sits between the USB-FIFO pin interface and the SoC-side stream fabric.

---
 rtl/ft_sync_fifo_bridge.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ft_sync_fifo_bridge.sv
// FT245-style synchronous FIFO bridge: host bus <-> two stream queues,
// with bus-turnaround FSM and error reporting.
module ft_sync_fifo_bridge #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      ad_i,
    output logic [WIDTH-1:0]      ad_o,
    output logic                  ad_oe,
    output logic                  txe,
    input  logic                  wr,
    output logic                  rxf,
    input  logic                  oe,
    input  logic                  rd,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DEPTH_LOG2:0]   down_level,
    output logic [DEPTH_LOG2:0]   up_level,
    output logic [CNT_W-1:0]      ovf_cnt,
    output logic [CNT_W-1:0]      udf_cnt,
    output logic                  proto_err,
    input  logic                  clr_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, TURN, DRIVE} state_t;

    state_t            state_q, state_d;
    logic              ad_oe_q, ad_oe_d;
    logic [PW-1:0]     dwp_q, dwp_d, drp_q, drp_d;
    logic [PW-1:0]     uwp_q, uwp_d, urp_q, urp_d;
    logic [CNT_W-1:0]  ovf_q, ovf_d, udf_q, udf_d;
    logic              perr_q, perr_d;
    logic [WIDTH-1:0]  dmem_q [DEPTH];
    logic [WIDTH-1:0]  umem_q [DEPTH];

    logic down_full, down_empty, up_full, up_empty;
    logic d_push, d_pop, u_push, u_pop;
    logic wr_bad, wr_ovf, rd_bad, rd_udf;

    assign down_empty = dwp_q == drp_q;
    assign up_empty   = uwp_q == urp_q;
    assign down_full  = (dwp_q[PW-1] != drp_q[PW-1]) &&
                        (dwp_q[PW-2:0] == drp_q[PW-2:0]);
    assign up_full    = (uwp_q[PW-1] != urp_q[PW-1]) &&
                        (uwp_q[PW-2:0] == urp_q[PW-2:0]);

    // Host strobes are only legal in the bus phase that owns them.
    always_comb begin
        wr_bad = wr && (state_q != IDLE || oe);
        wr_ovf = wr && !wr_bad && down_full;
        d_push = wr && !wr_bad && !down_full;
        d_pop  = !down_empty && m_ready;
        u_push = s_valid && !up_full;
        rd_bad = rd && state_q != DRIVE;
        u_pop  = rd && state_q == DRIVE && !up_empty;
        rd_udf = rd && state_q == DRIVE && up_empty;
    end

    always_comb begin
        dwp_d = dwp_q + PW'(d_push);
        drp_d = drp_q + PW'(d_pop);
        uwp_d = uwp_q + PW'(u_push);
        urp_d = urp_q + PW'(u_pop);

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (oe) state_d = TURN;
            TURN:    state_d = oe ? DRIVE : IDLE;
            DRIVE:   if (!oe) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ad_oe_d = state_d != IDLE;

        ovf_d  = ovf_q;
        udf_d  = udf_q;
        perr_d = perr_q || wr_bad || rd_bad;
        if (wr_ovf && ovf_q != {CNT_W{1'b1}}) ovf_d = ovf_q + CNT_W'(1);
        if (rd_udf && udf_q != {CNT_W{1'b1}}) udf_d = udf_q + CNT_W'(1);
        if (clr_err) begin
            ovf_d  = '0;
            udf_d  = '0;
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ad_oe_q <= 1'b0;
            dwp_q   <= '0;
            drp_q   <= '0;
            uwp_q   <= '0;
            urp_q   <= '0;
            ovf_q   <= '0;
            udf_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ad_oe_q <= ad_oe_d;
            dwp_q   <= dwp_d;
            drp_q   <= drp_d;
            uwp_q   <= uwp_d;
            urp_q   <= urp_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (d_push) dmem_q[dwp_q[PW-2:0]] <= ad_i;
        if (u_push) umem_q[uwp_q[PW-2:0]] <= s_data;
    end

    assign ad_oe      = ad_oe_q;
    assign ad_o       = (ad_oe_q && !up_empty) ? umem_q[urp_q[PW-2:0]]
                                                : {WIDTH{1'b1}};
    assign txe        = !down_full;
    assign rxf        = !up_empty;
    assign s_ready    = !up_full;
    assign m_valid    = !down_empty;
    assign m_data     = dmem_q[drp_q[PW-2:0]];
    assign down_level = dwp_q - drp_q;
    assign up_level   = uwp_q - urp_q;
    assign ovf_cnt    = ovf_q;
    assign udf_cnt    = udf_q;
    assign proto_err  = perr_q;

endmodule
